// File: rtl/knight_pkg.sv
// -----------------------------------------------------------------------------
// knight_pkg
// Shared constants and types for the knight's-tour command sequencer.
//   - Command opcodes (move / move with fanfare)
//   - Heading codes for the command heading field
//   - Response bytes returned to the UART
//   - Sequencer state enumeration
//   - make_cmd(): packs {opcode, heading, squares} into a 16-bit command
// -----------------------------------------------------------------------------
package knight_pkg;

  localparam logic [3:0] O_MOVE   = 4'h4;
  localparam logic [3:0] O_MOVE_F = 4'h5;

  localparam logic [7:0] H_NORTH  = 8'h00;
  localparam logic [7:0] H_WEST   = 8'h3F;
  localparam logic [7:0] H_SOUTH  = 8'h7F;
  localparam logic [7:0] H_EAST   = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  // Move register value out of reset (decodes as the bit0 move).
  localparam logic [7:0] MOVE_RESET = 8'h01;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    VERT      = 3'd2,
    VERT_WAIT = 3'd3,
    HORZ      = 3'd4,
    HORZ_WAIT = 3'd5
  } tour_state_t;

  function automatic logic [15:0] make_cmd(input logic [3:0] opcode,
                                           input logic [7:0] heading,
                                           input logic [3:0] squares);
    return {opcode, heading, squares};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// -----------------------------------------------------------------------------
// tour_move_decode
// Combinational translation of a one-hot knight move into the two commands
// that execute it: a vertical move followed by a horizontal move with fanfare.
// The lowest set bit selects the move; an all-zero move is treated as bit0.
//   move      in  8   one-hot move code
//   vert_cmd  out 16  vertical command   (opcode O_MOVE)
//   horz_cmd  out 16  horizontal command (opcode O_MOVE_F)
// -----------------------------------------------------------------------------
module tour_move_decode
  import knight_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic [7:0] vert_head_s;
  logic [3:0] vert_sq_s;
  logic [7:0] horz_head_s;
  logic [3:0] horz_sq_s;

  // Priority decode of the move bits into heading/distance for each axis.
  always_comb begin
    vert_head_s = H_NORTH;
    vert_sq_s   = 4'd2;
    horz_head_s = H_EAST;
    horz_sq_s   = 4'd1;
    if (move[0]) begin          // (+1,+2)
      vert_head_s = H_NORTH; vert_sq_s = 4'd2;
      horz_head_s = H_EAST;  horz_sq_s = 4'd1;
    end else if (move[1]) begin // (-1,+2)
      vert_head_s = H_NORTH; vert_sq_s = 4'd2;
      horz_head_s = H_WEST;  horz_sq_s = 4'd1;
    end else if (move[2]) begin // (-2,+1)
      vert_head_s = H_NORTH; vert_sq_s = 4'd1;
      horz_head_s = H_WEST;  horz_sq_s = 4'd2;
    end else if (move[3]) begin // (-2,-1)
      vert_head_s = H_SOUTH; vert_sq_s = 4'd1;
      horz_head_s = H_WEST;  horz_sq_s = 4'd2;
    end else if (move[4]) begin // (-1,-2)
      vert_head_s = H_SOUTH; vert_sq_s = 4'd2;
      horz_head_s = H_WEST;  horz_sq_s = 4'd1;
    end else if (move[5]) begin // (+1,-2)
      vert_head_s = H_SOUTH; vert_sq_s = 4'd2;
      horz_head_s = H_EAST;  horz_sq_s = 4'd1;
    end else if (move[6]) begin // (+2,-1)
      vert_head_s = H_SOUTH; vert_sq_s = 4'd1;
      horz_head_s = H_EAST;  horz_sq_s = 4'd2;
    end else if (move[7]) begin // (+2,+1)
      vert_head_s = H_NORTH; vert_sq_s = 4'd1;
      horz_head_s = H_EAST;  horz_sq_s = 4'd2;
    end else begin              // no bit set: same as bit0
      vert_head_s = H_NORTH; vert_sq_s = 4'd2;
      horz_head_s = H_EAST;  horz_sq_s = 4'd1;
    end
  end

  assign vert_cmd = make_cmd(O_MOVE,   vert_head_s, vert_sq_s);
  assign horz_cmd = make_cmd(O_MOVE_F, horz_head_s, horz_sq_s);

endmodule

// File: rtl/tour_cmd.sv
// -----------------------------------------------------------------------------
// tour_cmd
// Command sequencer between the UART command path, the tour solver's move
// memory and the command processor. In IDLE the UART command path is passed
// straight through. A start_tour pulse hands the command port to the
// sequencer, which replays NUM_MOVES solved moves as vertical/horizontal
// command pairs, handshaking each one with the command processor.
//   clk              in  1   system clock
//   rst              in  1   asynchronous active-high reset
//   start_tour       in  1   pulse that starts a tour (honoured in IDLE only)
//   move             in  8   one-hot move read from tour memory at mv_indx
//   mv_indx          out 5   move-memory read index
//   cmd_UART         in  16  command from the UART wrapper
//   cmd_rdy_UART     in  1   UART command valid
//   clr_cmd_rdy_UART out 1   clears the UART command valid
//   cmd              out 16  command to the command processor
//   cmd_rdy          out 1   command valid to the command processor
//   clr_cmd_rdy      in  1   command accepted by the command processor
//   send_resp        in  1   command completed by the command processor
//   resp             out 8   response byte to the UART (0xA5 / 0x5A)
// -----------------------------------------------------------------------------
module tour_cmd
  import knight_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_t state_r;
  tour_state_t state_nxt_s;
  logic [4:0]  mv_indx_r;
  logic [4:0]  mv_indx_nxt_s;
  logic [7:0]  move_q_r;
  logic [7:0]  move_q_nxt_s;
  logic [15:0] vert_cmd_s;
  logic [15:0] horz_cmd_s;
  logic        last_move_s;

  tour_move_decode u_decode (
    .move     (move_q_r),
    .vert_cmd (vert_cmd_s),
    .horz_cmd (horz_cmd_s)
  );

  assign last_move_s = (mv_indx_r == LAST_IDX);
  assign mv_indx     = mv_indx_r;

  // State, move index and latched move registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      mv_indx_r <= 5'd0;
      move_q_r  <= MOVE_RESET;
    end else begin
      state_r   <= state_nxt_s;
      mv_indx_r <= mv_indx_nxt_s;
      move_q_r  <= move_q_nxt_s;
    end
  end

  // Next-state logic: walks each move through its two handshaked commands.
  always_comb begin
    state_nxt_s   = state_r;
    mv_indx_nxt_s = mv_indx_r;
    move_q_nxt_s  = move_q_r;
    case (state_r)
      IDLE: begin
        if (start_tour) begin
          state_nxt_s   = LOAD;
          mv_indx_nxt_s = 5'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        // Memory data for the new index is valid during this cycle.
        move_q_nxt_s = move;
        state_nxt_s  = VERT;
      end
      VERT: begin
        if (clr_cmd_rdy) begin
          state_nxt_s = VERT_WAIT;
        end else begin
          state_nxt_s = VERT;
        end
      end
      VERT_WAIT: begin
        if (send_resp) begin
          state_nxt_s = HORZ;
        end else begin
          state_nxt_s = VERT_WAIT;
        end
      end
      HORZ: begin
        if (clr_cmd_rdy) begin
          state_nxt_s = HORZ_WAIT;
        end else begin
          state_nxt_s = HORZ;
        end
      end
      HORZ_WAIT: begin
        if (send_resp) begin
          if (last_move_s) begin
            state_nxt_s = IDLE;
          end else begin
            mv_indx_nxt_s = mv_indx_r + 5'd1;
            state_nxt_s   = LOAD;
          end
        end else begin
          state_nxt_s = HORZ_WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output mux: UART pass-through in IDLE, sequencer commands otherwise.
  always_comb begin
    cmd              = vert_cmd_s;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_ACK;
    case (state_r)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
      end
      LOAD: begin
        cmd = vert_cmd_s;
      end
      VERT: begin
        cmd     = vert_cmd_s;
        cmd_rdy = 1'b1;
      end
      VERT_WAIT: begin
        cmd = vert_cmd_s;
      end
      HORZ: begin
        cmd     = horz_cmd_s;
        cmd_rdy = 1'b1;
      end
      HORZ_WAIT: begin
        cmd = horz_cmd_s;
        if (last_move_s) begin
          resp = RESP_DONE;
        end else begin
          resp = RESP_ACK;
        end
      end
      default: begin
        cmd = vert_cmd_s;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// -----------------------------------------------------------------------------
// tb_tour_cmd
// Self-checking bench for tour_cmd: UART pass-through, a tour driven from a
// table of decode vectors, randomized tours checked against a reference
// model of the move rules, a tour with a UART command held pending, and a
// reset in the middle of a tour.
// -----------------------------------------------------------------------------
module tb_tour_cmd;

  localparam int NUM_MOVES = 24;
  localparam int TBL_N     = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cmds;

  logic [7:0]  mem      [0:31];
  logic [15:0] exp_vert [0:31];
  logic [15:0] exp_horz [0:31];

  int dx_tab [0:7] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_tab [0:7] = '{2, 2, 1, -1, -2, -2, -1, 1};

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] vert;
    logic [15:0] horz;
  } vec_t;
  vec_t vecs [0:TBL_N-1];

  tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  always #5 clk = ~clk;

  // Move memory with asynchronous read.
  assign move = mem[mv_indx];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: dx/dy of the lowest set bit, converted to heading + distance.
  function automatic void model_cmds(input logic [7:0] mv, output logic [15:0] v,
                                     output logic [15:0] h);
    int k;
    int dx;
    int dy;
    k = 0;
    for (int b = 7; b >= 0; b--) if (mv[b]) k = b;
    dx = dx_tab[k];
    dy = dy_tab[k];
    v = {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    h = {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
  endfunction

  task automatic prepare(input bit use_table);
    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      model_cmds(mem[i], exp_vert[i], exp_horz[i]);
    end
    if (use_table) begin
      for (int i = 0; i < TBL_N; i++) begin
        mem[i]      = vecs[i].mv;
        exp_vert[i] = vecs[i].vert;
        exp_horz[i] = vecs[i].horz;
      end
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 ns later.
  task automatic run_tour(input int rst_at);
    int d;
    n_cmds = 0;
    @(negedge clk); start_tour = 1'b1;
    @(negedge clk); start_tour = 1'b0; #1;
    check("load_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("load_mv_indx", {11'd0, mv_indx}, 16'd0);
    for (int i = 0; i < NUM_MOVES; i++) begin
      // VERT
      @(negedge clk); #1;
      check("vert_rdy", {15'd0, cmd_rdy}, 16'd1);
      check("vert_cmd", cmd, exp_vert[i]);
      check("vert_mv_indx", {11'd0, mv_indx}, 16'(i));
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge clk); send_resp = 1'($urandom_range(0, 1)); #1;
        check("vert_hold_rdy", {15'd0, cmd_rdy}, 16'd1);
      end
      @(negedge clk); send_resp = 1'b0; clr_cmd_rdy = 1'b1; #1;
      if (cmd_rdy) n_cmds++;
      check("vert_accept_cmd", cmd, exp_vert[i]);
      check("tour_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd0);
      // VERT_WAIT
      @(negedge clk); clr_cmd_rdy = 1'b0; #1;
      check("vwait_rdy", {15'd0, cmd_rdy}, 16'd0);
      check("vwait_cmd", cmd, exp_vert[i]);
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge clk); clr_cmd_rdy = 1'($urandom_range(0, 1)); #1;
        check("vwait_hold_rdy", {15'd0, cmd_rdy}, 16'd0);
      end
      @(negedge clk); clr_cmd_rdy = 1'b0; send_resp = 1'b1;
      // HORZ
      @(negedge clk); send_resp = 1'b0; #1;
      check("horz_rdy", {15'd0, cmd_rdy}, 16'd1);
      check("horz_cmd", cmd, exp_horz[i]);
      check("horz_resp", {8'd0, resp}, 16'h005A);
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge clk);
        send_resp  = 1'($urandom_range(0, 1));
        start_tour = 1'($urandom_range(0, 1));
        #1;
        check("horz_hold_cmd", cmd, exp_horz[i]);
      end
      @(negedge clk); send_resp = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b1; #1;
      if (cmd_rdy) n_cmds++;
      check("horz_accept_cmd", cmd, exp_horz[i]);
      // HORZ_WAIT
      @(negedge clk); clr_cmd_rdy = 1'b0; #1;
      check("hwait_rdy", {15'd0, cmd_rdy}, 16'd0);
      check("hwait_resp", {8'd0, resp}, (i == NUM_MOVES - 1) ? 16'h00A5 : 16'h005A);
      check("hwait_mv_indx", {11'd0, mv_indx}, 16'(i));
      if (i == rst_at) begin
        rst = 1'b1; #1;
        check("rst_mv_indx", {11'd0, mv_indx}, 16'd0);
        check("rst_cmd_rdy", {15'd0, cmd_rdy}, {15'd0, cmd_rdy_UART});
        check("rst_cmd", cmd, cmd_UART);
        check("rst_resp", {8'd0, resp}, 16'h00A5);
        #1 rst = 1'b0;
        return;
      end
      @(negedge clk); send_resp = 1'b1;
      @(negedge clk); send_resp = 1'b0; #1;
      if (i == NUM_MOVES - 1) begin
        check("end_idle_resp", {8'd0, resp}, 16'h00A5);
        check("end_idle_cmd", cmd, cmd_UART);
        check("end_idle_rdy", {15'd0, cmd_rdy}, {15'd0, cmd_rdy_UART});
      end else begin
        check("next_load_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("next_load_mv_indx", {11'd0, mv_indx}, 16'(i + 1));
      end
    end
    check("tour_cmd_count", 16'(n_cmds), 16'(2 * NUM_MOVES));
  endtask

  initial begin
    vecs[0]  = '{8'h01, 16'h4002, 16'h5BF1};
    vecs[1]  = '{8'h02, 16'h4002, 16'h53F1};
    vecs[2]  = '{8'h04, 16'h4001, 16'h53F2};
    vecs[3]  = '{8'h08, 16'h47F1, 16'h53F2};
    vecs[4]  = '{8'h10, 16'h47F2, 16'h53F1};
    vecs[5]  = '{8'h20, 16'h47F2, 16'h5BF1};
    vecs[6]  = '{8'h40, 16'h47F1, 16'h5BF2};
    vecs[7]  = '{8'h80, 16'h4001, 16'h5BF2};
    vecs[8]  = '{8'h00, 16'h4002, 16'h5BF1};
    vecs[9]  = '{8'h0A, 16'h4002, 16'h53F1};
    vecs[10] = '{8'hF0, 16'h47F2, 16'h53F1};
    vecs[11] = '{8'hC0, 16'h47F1, 16'h5BF2};

    rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    prepare(1'b1);
    #12;
    check("reset_mv_indx", {11'd0, mv_indx}, 16'd0);
    check("reset_resp", {8'd0, resp}, 16'h00A5);
    check("reset_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    @(negedge clk); rst = 1'b0;

    // UART pass-through in IDLE.
    @(negedge clk); cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1; #1;
    check("pass_cmd", cmd, 16'h2000);
    check("pass_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
    check("pass_resp", {8'd0, resp}, 16'h00A5);
    @(negedge clk); clr_cmd_rdy = 1'b1; #1;
    check("pass_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd1);
    @(negedge clk); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
    check("pass_clr_uart_low", {15'd0, clr_cmd_rdy_UART}, 16'd0);
    check("pass_cmd_rdy_low", {15'd0, cmd_rdy}, 16'd0);

    // Tour whose first moves come from the decode vector table.
    run_tour(-1);

    // Randomized tour with a UART command held pending throughout.
    prepare(1'b0);
    @(negedge clk); cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    run_tour(-1);
    @(negedge clk); #1;
    check("post_tour_cmd", cmd, 16'h1234);
    check("post_tour_rdy", {15'd0, cmd_rdy}, 16'd1);
    @(negedge clk); clr_cmd_rdy = 1'b1; #1;
    check("post_tour_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd1);
    @(negedge clk); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // Reset in HORZ_WAIT of move 7, then a full tour from move 0.
    prepare(1'b0);
    run_tour(7);
    @(negedge clk); #1;
    check("after_rst_resp", {8'd0, resp}, 16'h00A5);
    check("after_rst_mv_indx", {11'd0, mv_indx}, 16'd0);
    run_tour(-1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Command sequencer between the UART command path, the tour solver's move memory, and the command processor. In IDLE it passes UART commands straight through to the command processor. On `start_tour`, it takes control of the command port and replays the 24 solved knight moves. Each move is issued as two commands: a vertical move, then a horizontal move with fanfare. The block handshakes each command and returns progress responses to the UART.

## Interface
- `NUM_MOVES`, default 24 — number of moves in a tour (5x5 board minus start square).
- `clk`  in  1  — system clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `start_tour`  in  1  — 1-cycle pulse from the command processor (`tour_go`) that starts a tour.
- `move`  in  8  — one-hot move read from tour memory at `mv_indx`; valid 1 cycle after `mv_indx` changes.
- `mv_indx`  out  5  — move-memory read index, 0..NUM_MOVES-1.
- `cmd_UART`  in  16  — command from the UART wrapper.
- `cmd_rdy_UART`  in  1  — UART command valid.
- `clr_cmd_rdy_UART`  out  1  — clears the UART command valid.
- `cmd`  out  16  — command to the command processor.
- `cmd_rdy`  out  1  — command valid to the command processor.
- `clr_cmd_rdy`  in  1  — command accepted by the command processor.
- `send_resp`  in  1  — command completed, from the command processor.
- `resp`  out  8  — response byte to the UART: 0xA5 (done/idle) or 0x5A (tour in progress).

## Operation
- Command format: `{opcode[3:0], heading[7:0], squares[3:0]}`.
  - Opcode 0x4 = move; 0x5 = move with fanfare.
  - Heading: N=0x00, W=0x3F, S=0x7F, E=0xBF.
- Move decode (dx, dy):
  - bit0 (+1,+2), bit1 (−1,+2), bit2 (−2,+1), bit3 (−2,−1)
  - bit4 (−1,−2), bit5 (+1,−2), bit6 (+2,−1), bit7 (+2,+1)
  - Lowest set bit wins. 0x00 decodes as bit0.
- Vertical command: opcode 0x4, heading N if dy>0 else S, squares |dy|.
- Horizontal command: opcode 0x5, heading E if dx>0 else W, squares |dx|.
- States: IDLE, LOAD, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
  - IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`, `resp`=0xA5. On `start_tour`: `mv_indx`←0, go to LOAD.
  - LOAD: `move_q`←`move` (one cycle), go to VERT.
  - VERT: `cmd`=vertical command, `cmd_rdy`=1. On `clr_cmd_rdy` go to VERT_WAIT (`cmd_rdy` drops the next cycle).
  - VERT_WAIT: `cmd_rdy`=0, `cmd` held. On `send_resp` go to HORZ.
  - HORZ: `cmd`=horizontal command, `cmd_rdy`=1. On `clr_cmd_rdy` go to HORZ_WAIT.
  - HORZ_WAIT: on `send_resp`:
    - if `mv_indx`==NUM_MOVES−1, go to IDLE;
    - else `mv_indx`++ and go to LOAD.
- `resp` outside IDLE:
  - 0xA5 in HORZ_WAIT when `mv_indx`==NUM_MOVES−1;
  - otherwise 0x5A.
- While touring, UART commands are ignored and not consumed: `clr_cmd_rdy_UART`=0. A pending `cmd_rdy_UART` is serviced after return to IDLE.
- `start_tour` outside IDLE is ignored.
- `send_resp` in VERT or HORZ (before acceptance) is ignored.
- `clr_cmd_rdy` in a WAIT state is ignored.

## Timing
- Reset values: state IDLE, `mv_indx`=0, `move_q`=0x01. IDLE muxing then applies: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`, `resp`=0xA5.
- `start_tour` → LOAD the next cycle → `cmd_rdy`=1 with the vertical command 2 cycles after the pulse.
- All state-dependent outputs are combinational from registered state and `move_q`. IDLE pass-through is purely combinational (0 latency).
- `send_resp` in HORZ_WAIT → LOAD next cycle → next vertical command 2 cycles later.
- Reset mid-tour: immediate return to IDLE, `mv_indx`=0, `cmd_rdy` follows `cmd_rdy_UART`. No partial commands are re-issued.

## Structure
- Package `knight_pkg`:
  - opcode constants (`O_MOVE`, `O_MOVE_F`);
  - heading constants (`H_NORTH`/`H_WEST`/`H_SOUTH`/`H_EAST`);
  - response constants (`RESP_DONE`=0xA5, `RESP_ACK`=0x5A);
  - the `tour_state_t` enum.
- Sub-module `tour_move_decode`: one-hot move in → `{vert_cmd, horz_cmd}` out (combinational). All sequencing stays in `tour_cmd`.

## Test plan
- Reset, then `cmd_UART`=0x2000 with `cmd_rdy_UART`=1 → `cmd`=0x2000 and `cmd_rdy`=1 the same cycle. `clr_cmd_rdy` pulse → `clr_cmd_rdy_UART` pulse the same cycle. `resp`=0xA5.
- `start_tour`, `move`=0x01 → `cmd`=0x4002, `cmd_rdy`=1 at +2 cycles. Then `clr_cmd_rdy` and `send_resp` → `cmd`=0x5BF1, `resp`=0x5A.
- `move`=0x08 → vertical 0x47F1, then horizontal 0x53F2. `move`=0x00 → same commands as 0x01. `move`=0x0A → same as 0x02 (0x4002, 0x53F1).
- Full 24-move tour with a responding processor model → exactly 48 commands; `mv_indx` runs 0..23; `resp`=0xA5 only during the final HORZ_WAIT; returns to IDLE.
- `cmd_rdy_UART`=1 held throughout a tour → `clr_cmd_rdy_UART` stays 0 and the tour commands are unaffected. UART command passes through once back in IDLE.
- Assert `rst` in HORZ_WAIT at `mv_indx`=7 → IDLE and `mv_indx`=0 immediately. A new `start_tour` restarts from move 0.
